// File: rtl/spi_regmap_pkg.sv
// Shared definitions for the SPI register-write initiator: frame width,
// target register addresses, controller state encoding and frame packing.
package spi_regmap_pkg;

    localparam int FRAME_W = 16;

    // Register map of the on-chip SPI peripheral.
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } spi_ctrl_state_t;

    // Frame layout on the wire, MSB first: rw, address, data.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_ctrl_tick.sv
// SCLK half-period timer: pulses tick for one clk cycle every CLK_DIV cycles
// while enabled; the count restarts whenever the enable drops.
module spi_ctrl_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] half_cnt;

    assign tick = en && (half_cnt == LAST);

    // Count clk cycles within the current half-period; reload on each tick.
    always_ff @(posedge clk) begin
        // NOTE: flops are written with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst || !en) begin
            half_cnt <= '0;
        end else if (tick) begin
            half_cnt <= '0;
        end else begin
            half_cnt <= half_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_ctrl_writer.sv
// SPI mode-0 write initiator: turns one command transaction into a 16-bit
// MSB-first frame on sclk/copi/ncs, then holds ncs high for a minimum gap.
module spi_ctrl_writer
    import spi_regmap_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic       busy,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    spi_ctrl_state_t      state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 copi_q, copi_d;
    logic                 ncs_q, ncs_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 tick;
    logic                 tick_en;

    // The half-period timer only runs while ncs is low.
    assign tick_en = (state_q == SETUP) || (state_q == SHIFT);

    spi_ctrl_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        ncs_d     = ncs_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        ready_d   = ready_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = SETUP;
                    shreg_d = build_frame(cmd_rw, cmd_addr, cmd_data);
                    copi_d  = cmd_rw;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end

            SETUP: begin
                if (tick) begin
                    state_d   = SHIFT;
                    sclk_d    = 1'b1;
                    bit_cnt_d = 4'd15;
                end
            end

            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        // Falling edge: present the next bit, except after
                        // bit 0 whose value is held through its low phase.
                        sclk_d = 1'b0;
                        if (bit_cnt_q != 4'd0) begin
                            shreg_d = {shreg_q[FRAME_W-2:0], shreg_q[FRAME_W-1]};
                            copi_d  = shreg_q[FRAME_W-2];
                        end
                    end else if (bit_cnt_q == 4'd0) begin
                        state_d   = GAP;
                        ncs_d     = 1'b1;
                        copi_d    = 1'b0;
                        done_d    = 1'b1;
                        gap_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        sclk_d    = 1'b1;
                    end
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            ncs_q     <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            ncs_q     <= ncs_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;
    assign ncs       = ncs_q;

endmodule

// File: tb/tb_spi_ctrl_writer.sv
// Bench for spi_ctrl_writer: a timing model predicts every output cycle by
// cycle from the time since accept; a target model decodes the SPI stream
// into a register file; directed scenarios pin both with literal values.
module tb_spi_ctrl_writer;

    localparam int CD        = 4;
    localparam int CD2       = 2;
    localparam int GAPC      = 4;
    localparam int FRAME_CYC = 33 * CD;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_rw, cmd_ready, done, busy, sclk, copi, ncs;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;

    logic       v_2, rw_2, ready_2, done_2, busy_2, sclk_2, copi_2, ncs_2;
    logic [6:0] addr_2;
    logic [7:0] data_2;

    always #5 clk = ~clk;

    spi_ctrl_writer #(.CLK_DIV(CD), .GAP_CYCLES(GAPC)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .done(done), .busy(busy), .sclk(sclk), .copi(copi), .ncs(ncs)
    );

    spi_ctrl_writer #(.CLK_DIV(CD2), .GAP_CYCLES(GAPC)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(v_2), .cmd_ready(ready_2),
        .cmd_rw(rw_2), .cmd_addr(addr_2), .cmd_data(data_2),
        .done(done_2), .busy(busy_2), .sclk(sclk_2), .copi(copi_2), .ncs(ncs_2)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timing model ----------------
    bit          m_armed  = 1'b0;
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_frame  = '0;
    int          m_cycle  = 0;
    int          m_accepts = 0;
    int          m_last_accept = 0;
    int          m_prev_accept = 0;

    always @(posedge clk) begin
        m_cycle <= m_cycle + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_armed  <= 1'b1;
        end else if (m_active) begin
            if (m_t == FRAME_CYC + GAPC - 1) m_active <= 1'b0;
            else                             m_t <= m_t + 1;
        end else if (cmd_valid) begin
            m_active      <= 1'b1;
            m_t           <= 0;
            m_frame       <= {cmd_rw, cmd_addr, cmd_data};
            m_accepts     <= m_accepts + 1;
            m_prev_accept <= m_last_accept;
            m_last_accept <= m_cycle;
        end
    end

    // {ncs, sclk, copi, done, busy, cmd_ready} for cycle t after accept.
    function automatic logic [5:0] expect_outs(input bit active, input int t, input logic [15:0] f);
        int h;
        int idx;
        if (!active) return 6'b100001;
        if (t < FRAME_CYC) begin
            if (t < CD) return {1'b0, 1'b0, f[15], 3'b010};
            h   = (t - CD) / CD;
            idx = 15 - (h + 1) / 2;
            if (idx < 0) idx = 0;
            return {1'b0, (h % 2 == 0), f[idx], 3'b010};
        end
        return {3'b100, (t == FRAME_CYC), 2'b10};
    endfunction

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic [5:0] e;
        if (m_armed) begin
            e = expect_outs(m_active, m_t, m_frame);
            check("ncs",   32'(ncs),       32'(e[5]));
            check("sclk",  32'(sclk),      32'(e[4]));
            check("copi",  32'(copi),      32'(e[3]));
            check("done",  32'(done),      32'(e[2]));
            check("busy",  32'(busy),      32'(e[1]));
            check("ready", 32'(cmd_ready), 32'(e[0]));
        end
    end

    // ---------------- SPI target model (main DUT) ----------------
    logic [7:0]  regs [128] = '{default: 8'h00};
    logic        p_sclk = 1'b0, p_ncs = 1'b1;
    logic [15:0] sh = '0, last_stream = '0;
    int nb = 0, low_len = 0, high_len = 0;
    int last_nbits = 0, last_low_len = 0, last_high_len = 0;
    int frames = 0, dones = 0;

    always @(negedge clk) begin
        if (m_armed) begin
            if (done === 1'b1) dones <= dones + 1;
            if (ncs === 1'b0) begin
                if (p_ncs) begin
                    last_high_len <= high_len;
                    nb      <= 0;
                    low_len <= 1;
                end else begin
                    low_len <= low_len + 1;
                    if (!p_sclk && sclk === 1'b1) begin
                        sh <= {sh[14:0], copi};
                        nb <= nb + 1;
                    end
                end
            end else begin
                if (!p_ncs) begin
                    last_stream  <= sh;
                    last_nbits   <= nb;
                    last_low_len <= low_len;
                    frames       <= frames + 1;
                    if (nb == 16 && sh[15]) regs[sh[14:8]] <= sh[7:0];
                    high_len <= 1;
                end else begin
                    high_len <= high_len + 1;
                end
            end
            p_ncs  <= ncs;
            p_sclk <= sclk;
        end
    end

    // ---------------- phase monitor (CLK_DIV=2 DUT) ----------------
    logic        p2_sclk = 1'b0, p2_ncs = 1'b1;
    logic [15:0] d2_sh = '0;
    int d2_low_len = 0, d2_run = 0, d2_rises = 0, d2_dones = 0;
    int hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;

    always @(negedge clk) begin
        if (m_armed) begin
            if (done_2 === 1'b1) d2_dones <= d2_dones + 1;
            if (ncs_2 === 1'b0) begin
                if (p2_ncs) begin
                    d2_low_len <= 1;
                    d2_run     <= 1;
                    d2_rises   <= 0;
                end else begin
                    d2_low_len <= d2_low_len + 1;
                    if (sclk_2 !== p2_sclk) begin
                        if (p2_sclk) begin
                            if (d2_run < hi_min) hi_min <= d2_run;
                            if (d2_run > hi_max) hi_max <= d2_run;
                        end else begin
                            if (d2_run < lo_min) lo_min <= d2_run;
                            if (d2_run > lo_max) lo_max <= d2_run;
                        end
                        if (sclk_2 === 1'b1) begin
                            d2_rises <= d2_rises + 1;
                            d2_sh    <= {d2_sh[14:0], copi_2};
                        end
                        d2_run <= 1;
                    end else begin
                        d2_run <= d2_run + 1;
                    end
                end
            end else if (!p2_ncs) begin
                if (d2_run < lo_min) lo_min <= d2_run;
                if (d2_run > lo_max) lo_max <= d2_run;
            end
            p2_ncs  <= ncs_2;
            p2_sclk <= sclk_2;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_accepts(input int target, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (m_accepts >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int n0 = m_accepts;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_data  = d;
        wait_accepts(n0 + 1, "accept_wait");
        cmd_valid = 1'b0;
        cmd_addr  = 7'h7F;
        cmd_data  = 8'hEE;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!m_active) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_wait", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int d0, f0, n0;
        bit ok;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
        v_2 = 1'b0; rw_2 = 1'b0; addr_2 = '0; data_2 = '0;
        repeat (3) @(negedge clk);
        check("rst_ncs",   32'(ncs),       32'd1);
        check("rst_sclk",  32'(sclk),      32'd0);
        check("rst_copi",  32'(copi),      32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single write 0x00 <- 0xA5
        d0 = dones;
        send(1'b1, 7'h00, 8'hA5);
        wait_idle();
        check("w1_stream", 32'(last_stream), 32'h80A5);
        check("w1_nbits",  32'(last_nbits),  32'd16);
        check("w1_ncs_low", 32'(last_low_len), 32'd132);
        check("w1_done_cnt", 32'(dones - d0), 32'd1);
        check("w1_reg00", 32'(regs[0]), 32'hA5);

        // Back-to-back with cmd_valid held high
        n0 = m_accepts;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h04; cmd_data = 8'h80;
        wait_accepts(n0 + 1, "b2b_accept1");
        cmd_addr = 7'h02; cmd_data = 8'hFF;
        wait_accepts(n0 + 2, "b2b_accept2");
        cmd_valid = 1'b0;
        check("b2b_spacing", 32'(m_last_accept - m_prev_accept), 32'd137);
        repeat (2) @(negedge clk);
        check("b2b_ncs_gap", 32'(last_high_len), 32'd5);
        wait_idle();
        check("b2b_reg04", 32'(regs[4]), 32'h80);
        check("b2b_reg02", 32'(regs[2]), 32'hFF);

        // Command pulsed while busy is dropped
        d0 = dones; f0 = frames;
        send(1'b1, 7'h02, 8'h0F);
        repeat (40) @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h01; cmd_data = 8'h33;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        check("busy_frames", 32'(frames - f0), 32'd1);
        check("busy_dones",  32'(dones - d0),  32'd1);
        check("busy_stream", 32'(last_stream), 32'h820F);
        check("busy_reg01",  32'(regs[1]), 32'h00);
        check("busy_reg02",  32'(regs[2]), 32'h0F);

        // Reset abort in the middle of a frame
        send(1'b1, 7'h03, 8'h3C);
        wait_idle();
        check("abort_prior_reg03", 32'(regs[3]), 32'h3C);
        d0 = dones;
        send(1'b1, 7'h03, 8'h55);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (nb == 8) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_bit8_wait", 32'(ok), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ncs",   32'(ncs),       32'd1);
        check("abort_sclk",  32'(sclk),      32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_done",  32'(done),      32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(dones - d0), 32'd0);
        check("abort_nbits",   32'(last_nbits), 32'd8);
        check("abort_reg03",   32'(regs[3]), 32'h3C);

        // rw=0 frame goes out unchanged and writes nothing
        f0 = frames;
        send(1'b0, 7'h00, 8'hFF);
        wait_idle();
        check("rd_stream", 32'(last_stream), 32'h00FF);
        check("rd_frames", 32'(frames - f0), 32'd1);
        check("rd_reg00",  32'(regs[0]), 32'hA5);

        // CLK_DIV=2 instance
        @(negedge clk);
        v_2 = 1'b1; rw_2 = 1'b1; addr_2 = 7'h04; data_2 = 8'h3C;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_2 === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("cd2_accept_wait", 32'(ok), 32'd1);
        v_2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy_2 === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("cd2_idle_wait", 32'(ok), 32'd1);
        check("cd2_ncs_low", 32'(d2_low_len), 32'd66);
        check("cd2_hi_min",  32'(hi_min), 32'd2);
        check("cd2_hi_max",  32'(hi_max), 32'd2);
        check("cd2_lo_min",  32'(lo_min), 32'd2);
        check("cd2_lo_max",  32'(lo_max), 32'd2);
        check("cd2_rises",   32'(d2_rises), 32'd16);
        check("cd2_stream",  32'(d2_sh), 32'h843C);
        check("cd2_dones",   32'(d2_dones), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_ctrl_writer.md
Name: spi_ctrl_writer

Overview:
- SPI initiator that drives the 3-wire, write-only register interface of the on-chip SPI peripheral: SCLK, COPI and nCS (mode 0, MSB first).
- Turns one command-port transaction (rw, 7-bit address, 8-bit data) into one 16-bit frame.
- Used by the test harness and by a future on-chip sequencer to program the output-enable, PWM-enable and duty-cycle registers.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period. Legal range 2..255. Must be ≥4 when the target double-flop-synchronises SCLK on the same clk.
- GAP_CYCLES, 4: minimum clk cycles nCS stays high between frames. Legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_rw  in  1  frame bit 15; 1 = write
- cmd_addr  in  7  frame bits 14:8
- cmd_data  in  8  frame bits 7:0
- done  out  1  one-cycle pulse when a frame completes
- busy  out  1  high from accept until the end of the gap
- sclk  out  1  SPI clock; idles low
- copi  out  1  serial data
- ncs  out  1  chip select, active low; idles high

Behaviour:
- Reset: sclk=0, copi=0, ncs=1, done=0, busy=0, cmd_ready=1, state=IDLE. Reset wins over every other event, including mid-frame. A reset mid-frame forces ncs=1 on the next edge, so the target discards the partial frame.
- Accept: a command is accepted on an edge where cmd_valid && cmd_ready. At that edge:
  - frame = {cmd_rw, cmd_addr, cmd_data} is latched into a 16-bit shift register.
  - cmd_ready and busy change (1→0 and 0→1) on the accept edge.
  - cmd_* are don't-care afterwards.
- States: IDLE → SETUP → SHIFT → GAP → IDLE.
- SETUP (CLK_DIV cycles): ncs=0, sclk=0, copi=frame[15].
- SHIFT, per bit i = 15..0:
  - sclk=1 for CLK_DIV cycles; the target samples on the rising edge.
  - Then sclk=0 for CLK_DIV cycles.
  - On the sclk falling transition, copi advances to the next bit.
  - After bit 0's low phase, go to GAP. copi holds bit 0 through that low phase.
- Frame timing: ncs is low for exactly CLK_DIV + 32×CLK_DIV cycles. At the default this is 132 cycles, containing 16 rising sclk edges.
- GAP:
  - ncs=1, sclk=0, copi=0.
  - done=1 for exactly the first GAP cycle.
  - Stay for GAP_CYCLES cycles, then busy=0 and cmd_ready=1.
- Accept-to-next-accept minimum: 33×CLK_DIV + GAP_CYCLES + 1 cycles.
- cmd_valid while busy: ignored, with no queueing. The command is accepted once cmd_ready returns, if still asserted.
- cmd_rw=0: the frame is transmitted unchanged. The target ignores it; the block does not suppress it.
- Counters:
  - Half-period counter: 8 bits; it reloads and never wraps.
  - Bit counter: 4 bits, 15→0; the frame ends at the low phase of count 0.
- Outputs are registered with no glitches. sclk and ncs never change on the same clk edge, except on a reset abort.

Decomposition:
- Package spi_regmap_pkg:
  - FRAME_W=16.
  - Register addresses: ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03, ADDR_PWM_DUTY=0x04.
  - State enum spi_ctrl_state_t {IDLE, SETUP, SHIFT, GAP}.
- One sub-module: spi_ctrl_tick. It holds the half-period counter and emits a one-cycle tick every CLK_DIV cycles while enabled, and clears on disable or rst.
- The FSM and shift register stay in spi_ctrl_writer.

Test Plan:
- Single write, CLK_DIV=4, rw=1, addr=0x00, data=0xA5:
  - bits sampled at sclk rising edges = 1000_0000_1010_0101.
  - ncs low 132 cycles; done pulses once.
  - The peripheral's en_reg_out_7_0 reads 0xA5.
- Back-to-back: writes to 0x04←0x80 then 0x02←0xFF with cmd_valid held high.
  - Second accept occurs exactly 137 cycles after the first.
  - ncs high ≥4 cycles between frames; both registers update.
- Busy ignore: pulse cmd_valid with addr=0x01, data=0x33 mid-frame, then drop it.
  - Command is never sent; only the original frame appears; one done pulse.
- Reset abort: assert rst at bit 8 of a write to 0x03←0x55.
  - Next edge: ncs=1, sclk=0, cmd_ready=1, no done.
  - Peripheral register 0x03 keeps its prior value.
- rw=0 frame, addr=0x00, data=0xFF:
  - Stream = 0000_0000_1111_1111; peripheral registers unchanged.
- CLK_DIV=2 corner:
  - sclk high and low phases each exactly 2 cycles; ncs low 66 cycles.
